// File: rtl/reset_seq_pkg.sv
// Shared types, defaults and helpers for the NeoGS domain reset sequencer.
// Imported by reset_sequencer and its lowest-bit encoder.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_WAIT,
    S_GAP
  } state_e;

  typedef enum logic {
    M_PWR,
    M_SOFT
  } mode_e;

  localparam int unsigned DEF_NDOM     = 4;
  localparam int unsigned DEF_HOLD_CYC = 4;
  localparam int unsigned DEF_GAP_CYC  = 2;
  localparam int unsigned DEF_TMO_CYC  = 16;

  function automatic int unsigned cnt_width(
    input int unsigned h,
    input int unsigned g,
    input int unsigned t
  );
    int unsigned m;
    m = h;
    if (g > m) m = g;
    if (t > m) m = t;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  function automatic int unsigned lowest_set(
    input logic [63:0] v
  );
    int unsigned r;
    r = 0;
    for (int i = 63; i >= 0; i--) begin
      if (v[i]) r = unsigned'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/reset_sequencer_prio.sv
// Lowest-set-bit encoder: picks the lowest-index pending domain.
// vld is low when no request bit is set; idx is then 0.
module prio_lowest
  import reset_seq_pkg::*;
#(
  parameter int unsigned N  = DEF_NDOM,
  parameter int unsigned IW = $clog2(DEF_NDOM)
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          vld
);

  assign vld = |req;
  assign idx = IW'(lowest_set(64'(req)));

endmodule

// File: rtl/reset_sequencer.sv
// Per-domain reset sequencer: ordered power-up release with ready/timeout,
// then one-at-a-time software resets served lowest index first.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned NDOM     = DEF_NDOM,
  parameter int unsigned HOLD_CYC = DEF_HOLD_CYC,
  parameter int unsigned GAP_CYC  = DEF_GAP_CYC,
  parameter int unsigned TMO_CYC  = DEF_TMO_CYC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NDOM-1:0] soft_req,
  input  logic [NDOM-1:0] dom_rdy,
  output logic [NDOM-1:0] dom_rst,
  output logic            busy,
  output logic            seq_done,
  output logic [NDOM-1:0] tmo_err
);

  localparam int unsigned CW = cnt_width(HOLD_CYC, GAP_CYC, TMO_CYC);
  localparam int unsigned IW = $clog2(NDOM);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TMO_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NDOM - 1);

  state_e          state_q, state_d;
  mode_e           mode_q, mode_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NDOM-1:0] pending_q, pending_d;
  logic [NDOM-1:0] dom_rst_q, dom_rst_d;
  logic [NDOM-1:0] tmo_err_q, tmo_err_d;
  logic            seq_done_q, seq_done_d;

  logic [NDOM-1:0] pend_clr;
  logic [IW-1:0]   pend_idx;
  logic            pend_vld;
  logic            rdy_cur;
  logic            idx_last;

  prio_lowest #(
    .N  (NDOM),
    .IW (IW)
  ) u_prio (
    .req (pending_q),
    .idx (pend_idx),
    .vld (pend_vld)
  );

  assign rdy_cur  = dom_rdy[idx_q];
  assign idx_last = (idx_q == IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (pend_vld) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rdy_cur || cnt_q == TMO_LAST) state_d = S_GAP;
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          if (mode_q == M_PWR && !idx_last) state_d = S_HOLD;
          else                              state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idx_d      = idx_q;
    mode_d     = mode_q;
    dom_rst_d  = dom_rst_q;
    tmo_err_d  = tmo_err_q;
    seq_done_d = seq_done_q;
    pend_clr   = '0;
    if (state_d != state_q || state_q == S_IDLE) cnt_d = '0;
    else                                        cnt_d = cnt_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (pend_vld) begin
          idx_d               = pend_idx;
          dom_rst_d[pend_idx] = 1'b1;
          pend_clr[pend_idx]  = 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) dom_rst_d[idx_q] = 1'b0;
      end
      S_WAIT: begin
        // a timed-out domain stays released; only the flag records it
        if (!rdy_cur && cnt_q == TMO_LAST) tmo_err_d[idx_q] = 1'b1;
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST && mode_q == M_PWR) begin
          if (!idx_last) begin
            idx_d = idx_q + 1'b1;
          end else begin
            seq_done_d = 1'b1;
            mode_d     = M_SOFT;
          end
        end
      end
      default: ;
    endcase
    pending_d = (pending_q & ~pend_clr) | soft_req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= M_PWR;
      idx_q      <= '0;
      cnt_q      <= '0;
      pending_q  <= '0;
      dom_rst_q  <= '1;
      tmo_err_q  <= '0;
      seq_done_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      dom_rst_q  <= dom_rst_d;
      tmo_err_q  <= tmo_err_d;
      seq_done_q <= seq_done_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign dom_rst  = dom_rst_q;
  assign tmo_err  = tmo_err_q;
  assign seq_done = seq_done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: a scoreboard of expected
// dom_rst edges plus inline checks of busy/seq_done/tmo_err.
module tb_reset_sequencer;

  localparam int NDOM = 4;
  localparam int HOLD = 4;
  localparam int GAP  = 2;
  localparam int TMO  = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NDOM-1:0] soft_req = '0;
  logic [NDOM-1:0] dom_rdy  = '1;
  logic [NDOM-1:0] dom_rst;
  logic            busy;
  logic            seq_done;
  logic [NDOM-1:0] tmo_err;

  typedef struct {
    int   at;
    int   dom;
    logic val;
  } ev_t;

  ev_t             exp_q[$];
  int              ec;
  int              errors = 0;
  int              checks = 0;
  logic [NDOM-1:0] prev;

  reset_sequencer #(
    .NDOM     (NDOM),
    .HOLD_CYC (HOLD),
    .GAP_CYC  (GAP),
    .TMO_CYC  (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .soft_req (soft_req),
    .dom_rdy  (dom_rdy),
    .dom_rst  (dom_rst),
    .busy     (busy),
    .seq_done (seq_done),
    .tmo_err  (tmo_err)
  );

  always #5 clk = ~clk;

  // edge counter (edge 1 = first edge with rst low) and dom_rst scoreboard
  always @(posedge clk) begin : mon
    logic rs;
    ev_t  ev;
    rs = rst;
    if (rs) ec = 0;
    else    ec = ec + 1;
    #1;
    if (!rs) begin
      for (int d = 0; d < NDOM; d++) begin
        if (dom_rst[d] !== prev[d]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected edge=%0d dom=%0d got=%b want=no change",
                     ec, d, dom_rst[d]);
          end else begin
            ev = exp_q.pop_front();
            if (ev.at != ec || ev.dom != d || ev.val !== dom_rst[d]) begin
              errors++;
              $display("FAIL sb_event got edge=%0d dom=%0d val=%b want edge=%0d dom=%0d val=%b",
                       ec, d, dom_rst[d], ev.at, ev.dom, ev.val);
            end
          end
        end
      end
    end
    prev = dom_rst;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  task automatic goto(input int n);
    int guard;
    guard = 0;
    while (ec != n && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (ec != n) begin
      errors++;
      $display("FAIL goto got=%0d want=%0d", ec, n);
    end
  endtask

  task automatic push_powerup(input logic [NDOM-1:0] rdy, output int done);
    int t;
    int rel;
    t = 0;
    for (int d = 0; d < NDOM; d++) begin
      rel = t + HOLD;
      exp_q.push_back('{at: rel, dom: d, val: 1'b0});
      t = rel + (rdy[d] ? 1 : TMO) + GAP;
    end
    done = t;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (dom_rst !== 4'hF) begin
      errors++; $display("FAIL rst_dom_rst got=%b want=1111", dom_rst);
    end
    checks++;
    if (tmo_err !== 4'h0) begin
      errors++; $display("FAIL rst_tmo_err got=%b want=0000", tmo_err);
    end
    checks++;
    if (seq_done !== 1'b0) begin
      errors++; $display("FAIL rst_seq_done got=%b want=0", seq_done);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL rst_busy got=%b want=1", busy);
    end
  endtask

  task automatic test_powerup(input logic [NDOM-1:0] rdy, input int soft_at,
                              input logic [NDOM-1:0] soft_v, input int tmo_at);
    int done;
    exp_q.delete();
    dom_rdy = rdy;
    test_reset();
    push_powerup(rdy, done);
    if (soft_v != 0) begin
      exp_q.push_back('{at: done + 1, dom: 0, val: 1'b1});
      exp_q.push_back('{at: done + 1 + HOLD, dom: 0, val: 1'b0});
    end
    rst = 1'b0;
    if (soft_v != 0) begin
      goto(soft_at - 1);
      soft_req = soft_v;
      goto(soft_at);
      soft_req = '0;
    end
    if (tmo_at > 0) begin
      goto(tmo_at - 1);
      checks++;
      if (tmo_err !== 4'h0) begin
        errors++; $display("FAIL pre_tmo got=%b want=0000", tmo_err);
      end
      goto(tmo_at);
      checks++;
      if (tmo_err !== ~rdy) begin
        errors++; $display("FAIL tmo_flag got=%b want=%b", tmo_err, ~rdy);
      end
    end
    goto(done - 1);
    checks++;
    if (seq_done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL pre_done got=%b%b want=01", seq_done, busy);
    end
    goto(done);
    checks++;
    if (seq_done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL seq_done got done=%b busy=%b want done=1 busy=0 (edge %0d)",
                         seq_done, busy, done);
    end
    checks++;
    if (tmo_err !== ~rdy) begin
      errors++; $display("FAIL done_tmo got=%b want=%b", tmo_err, ~rdy);
    end
    if (soft_v != 0) begin
      goto(done + 1);
      checks++;
      if (busy !== 1'b1 || dom_rst !== 4'b0001) begin
        errors++; $display("FAIL late_soft got busy=%b rst=%b want busy=1 rst=0001", busy, dom_rst);
      end
      goto(done + 8);
      checks++;
      if (busy !== 1'b0) begin
        errors++; $display("FAIL late_soft_end got=%b want=0", busy);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL powerup_left got=%0d want=0", exp_q.size());
    end
  endtask

  task automatic test_soft_single();
    int e;
    e = ec + 2;
    exp_q.push_back('{at: e + 1, dom: 2, val: 1'b1});
    exp_q.push_back('{at: e + 1 + HOLD, dom: 2, val: 1'b0});
    goto(e - 1);
    soft_req = 4'b0100;
    goto(e);
    soft_req = '0;
    goto(e + 1);
    checks++;
    if (busy !== 1'b1 || dom_rst !== 4'b0100) begin
      errors++; $display("FAIL soft1_start got busy=%b rst=%b want busy=1 rst=0100", busy, dom_rst);
    end
    goto(e + 7);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL soft1_busy got=%b want=1", busy);
    end
    goto(e + 8);
    checks++;
    if (busy !== 1'b0 || dom_rst !== 4'b0000) begin
      errors++; $display("FAIL soft1_end got busy=%b rst=%b want busy=0 rst=0000", busy, dom_rst);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL soft1_left got=%0d want=0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int e;
    int s;
    int order[3];
    order = '{1, 1, 3};
    e = ec + 2;
    for (int k = 0; k < 3; k++) begin
      s = e + 1 + 8 * k;
      exp_q.push_back('{at: s, dom: order[k], val: 1'b1});
      exp_q.push_back('{at: s + HOLD, dom: order[k], val: 1'b0});
    end
    goto(e - 1);
    soft_req = 4'b1010;
    goto(e);
    soft_req = '0;
    goto(e + 1);
    checks++;
    if (dom_rst !== 4'b0010) begin
      errors++; $display("FAIL b2b_first got=%b want=0010", dom_rst);
    end
    goto(e + 2);
    soft_req = 4'b1010;
    goto(e + 3);
    soft_req = '0;
    goto(e + 24);
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_end got busy=%b left=%0d want busy=0 left=0", busy, exp_q.size());
    end
    goto(e + 32);
    checks++;
    if (busy !== 1'b0 || dom_rst !== 4'b0000) begin
      errors++; $display("FAIL b2b_quiet got busy=%b rst=%b want busy=0 rst=0000", busy, dom_rst);
    end
  endtask

  task automatic test_rst_mid();
    int done;
    exp_q.delete();
    dom_rdy = 4'b1101;
    test_reset();
    exp_q.push_back('{at: 4, dom: 0, val: 1'b0});
    exp_q.push_back('{at: 11, dom: 1, val: 1'b0});
    exp_q.push_back('{at: 33, dom: 2, val: 1'b0});
    rst = 1'b0;
    goto(35);
    checks++;
    if (tmo_err !== 4'b0010 || dom_rst !== 4'b1000) begin
      errors++; $display("FAIL mid_state got tmo=%b rst=%b want tmo=0010 rst=1000", tmo_err, dom_rst);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (dom_rst !== 4'hF || tmo_err !== 4'h0 || seq_done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_rst got rst=%b tmo=%b done=%b busy=%b want 1111 0000 0 1",
                         dom_rst, tmo_err, seq_done, busy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL mid_left got=%0d want=0", exp_q.size());
    end
    dom_rdy = 4'hF;
    push_powerup(4'hF, done);
    rst = 1'b0;
    goto(done);
    checks++;
    if (seq_done !== 1'b1 || busy !== 1'b0 || tmo_err !== 4'h0) begin
      errors++; $display("FAIL mid_restart got done=%b busy=%b tmo=%b want 1 0 0000",
                         seq_done, busy, tmo_err);
    end
    checks++;
    if (done != 28 || exp_q.size() != 0) begin
      errors++; $display("FAIL mid_restart_sb got done=%0d left=%0d want 28 0", done, exp_q.size());
    end
  endtask

  initial begin
    test_powerup(4'hF, 0, 4'h0, 0);
    test_soft_single();
    test_back_to_back();
    test_powerup(4'b1101, 0, 4'h0, 27);
    test_powerup(4'hF, 10, 4'b0001, 0);
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
